stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control and scheduling block for the MM:SS stopwatch. Owns the run/pause/adjust mode state machine, debounces the pause button, generates all clock-enable pulses that advance or adjust the BCD time counters, and schedules the 4-digit seven-segment scan (anode select plus blink masking). It sits between the board inputs and the counter/decoder datapath; the counters advance only on its pulses, and the display mux follows its `digit_sel`.

## Interface
- `TICK_DIV`, 100_000_000: cycles per 1 Hz count pulse.
- `ADJ_DIV`, 50_000_000: cycles per adjust step (2 Hz).
- `BLINK_DIV`, 25_000_000: cycles per blink phase toggle.
- `SCAN_DIV`, 100_000: cycles per display digit slot.
- `DB_CYCLES`, 1_000_000: cycles `pause` must be stable to be accepted.

- `clk` in 1: system clock.
- `resett` in 1: reset, asynchronous, active-low.
- `pause` in 1: raw pause pushbutton, asynchronous.
- `select` in 1: adjust field; 0 = minutes, 1 = seconds. Asynchronous.
- `adj` in 2: `adj[0]` = adjust mode; `adj[1]` = fast adjust (step period ADJ_DIV/4). Asynchronous.
- `run` out 1: run flag (1 = counting when not adjusting).
- `cnt_en` out 1: one-cycle pulse, advance time by 1 s.
- `adj_min_en` out 1: one-cycle pulse, increment minutes field.
- `adj_sec_en` out 1: one-cycle pulse, increment seconds field.
- `digit_sel` out 2: scanned digit; 0 = sec0, 1 = sec1, 2 = min0, 3 = min1.
- `an` out 4: active-low anode enables, one-cold.
- `digit_blank` out 1: blank the currently scanned digit.

## Operation
- `select`, `adj`: 2-FF synchronized before use. `pause`: 2-FF synchronized, then debounced; accepted level changes only after DB_CYCLES consecutive identical samples; a debounced 0→1 edge yields one `press` pulse.
- Mode FSM states: RUN, PAUSED, ADJUST.
  - RUN → PAUSED on `press`; PAUSED → RUN on `press`. `run` tracks RUN/PAUSED.
  - Any state → ADJUST when synced `adj[0]`=1. In ADJUST, `press` toggles `run` but state stays ADJUST.
  - ADJUST → RUN or PAUSED (per `run`) when `adj[0]`=0.
- Tick divider: counts 0..TICK_DIV-1 only in RUN; at TICK_DIV-1 pulses `cnt_en` and wraps to 0. Holds value in PAUSED (fraction preserved). Cleared to 0 on entry to ADJUST.
- Adjust divider: cleared on ADJUST entry; in ADJUST counts to ADJ_DIV-1 (ADJ_DIV/4-1 if `adj[1]`), then pulses `adj_sec_en` if `select`=1 else `adj_min_en`, and wraps. Change of `adj[1]` or `select` does not clear it.
- Blink: free-running divider toggles blink phase every BLINK_DIV cycles.
- Scan: free-running divider; every SCAN_DIV cycles `digit_sel` increments mod 4 (3→0 wrap); `an` = ~(1 << `digit_sel`), updated in the same edge.
- `digit_blank` = ADJUST && blink phase && scanned digit in selected field (`select`=1: digits 0,1; `select`=0: digits 2,3).
- At most one of `cnt_en`, `adj_min_en`, `adj_sec_en` is high in any cycle.

## Timing
- All outputs registered. Reset values: state RUN, `run`=1, pulses 0, blink phase 0, `digit_sel`=0, `an`=4'b1110, `digit_blank`=0, all dividers 0.
- First `cnt_en` after reset release: edge TICK_DIV (dividers count from first active edge).
- `pause` → `run` toggle: 2 sync + DB_CYCLES + 1 cycles after the stable level.
- `adj[0]` rise → no `cnt_en` from 3 cycles later; first adjust pulse ADJ_DIV cycles after ADJUST entry.
- `press` coincident with `adj[0]` rise: enter ADJUST and toggle `run`.
- `cnt_en` due in the same cycle ADJUST is entered: suppressed.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

## Structure
- `stopwatch_pkg`: mode state enum, digit index constants (SEC0..MIN1), anode-encode function.
- Sub-module `btn_debounce` (synchronizer + stability counter + edge pulse), parameter DB_CYCLES.

## Test plan
Parameters TICK_DIV=10, ADJ_DIV=8, BLINK_DIV=3, SCAN_DIV=2, DB_CYCLES=3.
- Reset released, inputs 0 → `cnt_en` on cycles 10, 20, 30; `an` sequence 1110, 1101, 1011, 0111, 1110 every 2 cycles.
- `pause` held high 6 cycles at cycle 14 → `run`=0, no `cnt_en` until second press; after resume next `cnt_en` at residual count (not 10 cycles).
- `pause` glitch 2 cycles wide → `run` unchanged.
- `adj`=01, `select`=1 → `cnt_en` stops; `adj_sec_en` every 8 cycles; `digit_blank` high only on digits 0/1 during blink phase 1.
- `adj`=11, `select`=0 → `adj_min_en` every 2 cycles; clearing `adj` returns to prior RUN/PAUSED.
- Assert `resett`=0 mid-ADJUST → outputs at reset values within same cycle; `an`=1110.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and helpers for the MM:SS stopwatch control block.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } mode_t;

    // Scan order of the four display digits, least significant first.
    localparam logic [1:0] SEC0 = 2'd0;
    localparam logic [1:0] SEC1 = 2'd1;
    localparam logic [1:0] MIN0 = 2'd2;
    localparam logic [1:0] MIN1 = 2'd3;

    // One-cold anode pattern for a digit index (anodes are active-low).
    function automatic logic [3:0] anode_encode(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce: two-flop synchronizer, stability counter and rising-edge press pulse.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic resett,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or negedge resett) begin
        if (!resett) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], btn_raw};
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples; pulse on a new high level.
    always_ff @(posedge clk or negedge resett) begin
        if (!resett) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mode FSM, count/adjust pulse generation and display scan scheduling.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int ADJ_DIV   = 50_000_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int SCAN_DIV  = 100_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       resett,
    input  logic       pause,
    input  logic       select,
    input  logic [1:0] adj,
    output logic       run,
    output logic       cnt_en,
    output logic       adj_min_en,
    output logic       adj_sec_en,
    output logic [1:0] digit_sel,
    output logic [3:0] an,
    output logic       digit_blank
);
    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int AW = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam logic [AW-1:0] ADJ_LIM_SLOW = AW'(ADJ_DIV - 1);
    localparam logic [AW-1:0] ADJ_LIM_FAST = AW'((ADJ_DIV / 4 > 0) ? ADJ_DIV / 4 - 1 : 0);

    logic          sel_meta, sel_s;
    logic [1:0]    adj_meta, adj_s;
    logic          press;
    mode_t         state, state_nxt;
    logic          run_nxt;
    logic          tick_active, adj_active, adj_entry;
    logic [AW-1:0] adj_limit;
    logic [TW-1:0] tick_cnt;
    logic [AW-1:0] adj_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink, blink_nxt;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit_nxt;
    logic          in_field;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_pause_db (
        .clk    (clk),
        .resett (resett),
        .btn_raw(pause),
        .press  (press)
    );

    // Two-flop synchronizers for the level-type switches.
    always_ff @(posedge clk or negedge resett) begin
        if (!resett) begin
            sel_meta <= 1'b0;
            sel_s    <= 1'b0;
            adj_meta <= 2'b00;
            adj_s    <= 2'b00;
        end else begin
            sel_meta <= select;
            sel_s    <= sel_meta;
            adj_meta <= adj;
            adj_s    <= adj_meta;
        end
    end

    // Mode state and run flag.
    always_ff @(posedge clk or negedge resett) begin
        if (!resett) begin
            state <= ST_RUN;
            run   <= 1'b1;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
        end
    end

    // A press always flips run; adjust mode overrides, otherwise the state follows run.
    always_comb begin
        run_nxt   = run ^ press;
        state_nxt = run_nxt ? ST_RUN : ST_PAUSED;
        if (adj_s[0]) begin
            state_nxt = ST_ADJUST;
        end
    end

    // Decode which dividers are active this cycle and the adjust step period.
    always_comb begin
        tick_active = (state == ST_RUN);
        adj_active  = (state == ST_ADJUST);
        adj_entry   = (state != ST_ADJUST) && (state_nxt == ST_ADJUST);
        adj_limit   = adj_s[1] ? ADJ_LIM_FAST : ADJ_LIM_SLOW;
    end

    // One-second divider; entering adjust wins over a pulse due the same cycle.
    always_ff @(posedge clk or negedge resett) begin
        if (!resett) begin
            tick_cnt <= '0;
            cnt_en   <= 1'b0;
        end else begin
            cnt_en <= 1'b0;
            if (adj_entry) begin
                tick_cnt <= '0;
            end else if (tick_active) begin
                if (tick_cnt == TW'(TICK_DIV - 1)) begin
                    tick_cnt <= '0;
                    cnt_en   <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    // Adjust step divider; >= lets a switch to fast mode wrap a count already past the short limit.
    always_ff @(posedge clk or negedge resett) begin
        if (!resett) begin
            adj_cnt    <= '0;
            adj_min_en <= 1'b0;
            adj_sec_en <= 1'b0;
        end else begin
            adj_min_en <= 1'b0;
            adj_sec_en <= 1'b0;
            if (!adj_active) begin
                adj_cnt <= '0;
            end else if (adj_cnt >= adj_limit) begin
                adj_cnt <= '0;
                if (sel_s) begin
                    adj_sec_en <= 1'b1;
                end else begin
                    adj_min_en <= 1'b1;
                end
            end else begin
                adj_cnt <= adj_cnt + 1'b1;
            end
        end
    end

    // Next blink phase, next scanned digit and whether that digit belongs to the selected field.
    always_comb begin
        blink_nxt = blink;
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_nxt = ~blink;
        end
        digit_nxt = digit_sel;
        if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            digit_nxt = (digit_sel == MIN1) ? SEC0 : digit_sel + 2'd1;
        end
        in_field = sel_s ? (digit_nxt <= SEC1) : (digit_nxt >= MIN0);
    end

    // Free-running blink and scan dividers with registered display outputs.
    always_ff @(posedge clk or negedge resett) begin
        if (!resett) begin
            blink_cnt   <= '0;
            blink       <= 1'b0;
            scan_cnt    <= '0;
            digit_sel   <= SEC0;
            an          <= 4'b1110;
            digit_blank <= 1'b0;
        end else begin
            blink_cnt   <= (blink_cnt == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt + 1'b1;
            blink       <= blink_nxt;
            scan_cnt    <= (scan_cnt == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt + 1'b1;
            digit_sel   <= digit_nxt;
            an          <= anode_encode(digit_nxt);
            digit_blank <= (state_nxt == ST_ADJUST) && blink_nxt && in_field;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard plus table-driven and hand-timed checks for stopwatch_ctrl.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int ADJ_DIV   = 8;
    localparam int BLINK_DIV = 3;
    localparam int SCAN_DIV  = 2;
    localparam int DB_CYCLES = 3;
    localparam int M_RUN     = 0;
    localparam int M_PAUSED  = 1;
    localparam int M_ADJ     = 2;

    logic       clk;
    logic       resett;
    logic       pause;
    logic       select;
    logic [1:0] adj;
    logic       run;
    logic       cnt_en;
    logic       adj_min_en;
    logic       adj_sec_en;
    logic [1:0] digit_sel;
    logic [3:0] an;
    logic       digit_blank;

    typedef struct {
        logic       run;
        logic       cnt_en;
        logic       adj_min_en;
        logic       adj_sec_en;
        logic [1:0] digit_sel;
        logic [3:0] an;
        logic       digit_blank;
    } exp_t;

    typedef struct {
        int         hold;
        logic       pause;
        logic       select;
        logic [1:0] adj;
        logic       exp_run;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[11];
    int         n_vectors     = 0;
    int         n_miscompares = 0;
    logic [3:0] an_tab[4]     = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int         m_cyc;
    logic       m_p1, m_p2, m_plev, m_press;
    int         m_pcnt;
    logic       m_s1, m_s2;
    logic [1:0] m_a1, m_a2;
    int         m_state;
    logic       m_run;
    int         m_tick;
    int         m_adjc;

    stopwatch_ctrl #(
        .TICK_DIV (TICK_DIV),
        .ADJ_DIV  (ADJ_DIV),
        .BLINK_DIV(BLINK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk        (clk),
        .resett     (resett),
        .pause      (pause),
        .select     (select),
        .adj        (adj),
        .run        (run),
        .cnt_en     (cnt_en),
        .adj_min_en (adj_min_en),
        .adj_sec_en (adj_sec_en),
        .digit_sel  (digit_sel),
        .an         (an),
        .digit_blank(digit_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: predicts the outputs after each active edge and queues them.
    always @(posedge clk or negedge resett) begin : ref_model
        logic nx_press, nx_run, entry, e_cnt, e_min, e_sec, blink_ph;
        int   nx_state, lim, d;
        exp_t e;
        if (!resett) begin
            m_cyc = 0; m_p1 = 0; m_p2 = 0; m_plev = 0; m_pcnt = 0; m_press = 0;
            m_s1 = 0; m_s2 = 0; m_a1 = 2'b00; m_a2 = 2'b00;
            m_state = M_RUN; m_run = 1; m_tick = 0; m_adjc = 0;
            exp_q.delete();
        end else begin
            m_cyc++;
            nx_press = 0;
            if (m_p2 == m_plev) begin
                m_pcnt = 0;
            end else if (m_pcnt == DB_CYCLES - 1) begin
                m_plev = m_p2; m_pcnt = 0; nx_press = m_p2;
            end else begin
                m_pcnt++;
            end
            nx_run   = m_run ^ m_press;
            nx_state = m_a2[0] ? M_ADJ : (nx_run ? M_RUN : M_PAUSED);
            entry    = (m_state != M_ADJ) && (nx_state == M_ADJ);
            e_cnt = 0;
            if (entry) begin
                m_tick = 0;
            end else if (m_state == M_RUN) begin
                m_tick++;
                if (m_tick == TICK_DIV) begin m_tick = 0; e_cnt = 1; end
            end
            e_min = 0; e_sec = 0;
            lim = m_a2[1] ? ADJ_DIV / 4 : ADJ_DIV;
            if (m_state != M_ADJ) begin
                m_adjc = 0;
            end else begin
                m_adjc++;
                if (m_adjc >= lim) begin
                    m_adjc = 0;
                    if (m_s2) e_sec = 1; else e_min = 1;
                end
            end
            d        = (m_cyc / SCAN_DIV) % 4;
            blink_ph = ((m_cyc / BLINK_DIV) % 2) == 1;
            e.run         = nx_run;
            e.cnt_en      = e_cnt;
            e.adj_min_en  = e_min;
            e.adj_sec_en  = e_sec;
            e.digit_sel   = 2'(d);
            e.an          = an_tab[d];
            e.digit_blank = (nx_state == M_ADJ) && blink_ph && (m_s2 ? (d < 2) : (d >= 2));
            exp_q.push_back(e);
            m_state = nx_state; m_run = nx_run; m_press = nx_press;
            m_p2 = m_p1; m_p1 = pause;
            m_s2 = m_s1; m_s1 = select;
            m_a2 = m_a1; m_a1 = adj;
        end
    end

    task automatic check_val(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, m_cyc, actual, expected);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check_val("run",         8'(run),         8'(e.run));
        check_val("cnt_en",      8'(cnt_en),      8'(e.cnt_en));
        check_val("adj_min_en",  8'(adj_min_en),  8'(e.adj_min_en));
        check_val("adj_sec_en",  8'(adj_sec_en),  8'(e.adj_sec_en));
        check_val("digit_sel",   8'(digit_sel),   8'(e.digit_sel));
        check_val("an",          8'(an),          8'(e.an));
        check_val("digit_blank", 8'(digit_blank), 8'(e.digit_blank));
        check_val("one_pulse",   8'((int'(cnt_en) + int'(adj_min_en) + int'(adj_sec_en)) <= 1), 8'(1));
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_run"},   8'(run),         8'(1));
        check_val({tag, "_cnt"},   8'(cnt_en),      8'(0));
        check_val({tag, "_min"},   8'(adj_min_en),  8'(0));
        check_val({tag, "_sec"},   8'(adj_sec_en),  8'(0));
        check_val({tag, "_digit"}, 8'(digit_sel),   8'(0));
        check_val({tag, "_an"},    8'(an),          8'(4'b1110));
        check_val({tag, "_blank"}, 8'(digit_blank), 8'(0));
    endtask

    task automatic apply_stimulus(input logic p, input logic s, input logic [1:0] a);
        pause  = p;
        select = s;
        adj    = a;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_output();
    endtask

    task automatic do_reset();
        resett = 1'b0;
        apply_stimulus(1'b0, 1'b0, 2'b00);
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        resett = 1'b1;
    endtask

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence: free run, pause/resume, table of mode changes, adjust modes, async reset.
    initial begin
        vecs[0]  = '{4,  1'b0, 1'b0, 2'b00, 1'b1};
        vecs[1]  = '{2,  1'b1, 1'b0, 2'b00, 1'b1};
        vecs[2]  = '{8,  1'b0, 1'b0, 2'b00, 1'b1};
        vecs[3]  = '{6,  1'b1, 1'b0, 2'b00, 1'b0};
        vecs[4]  = '{6,  1'b0, 1'b0, 2'b00, 1'b0};
        vecs[5]  = '{12, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[6]  = '{6,  1'b0, 1'b0, 2'b00, 1'b0};
        vecs[7]  = '{8,  1'b0, 1'b1, 2'b01, 1'b0};
        vecs[8]  = '{6,  1'b1, 1'b1, 2'b01, 1'b1};
        vecs[9]  = '{6,  1'b0, 1'b1, 2'b01, 1'b1};
        vecs[10] = '{12, 1'b0, 1'b0, 2'b00, 1'b1};

        resett = 1'b0;
        apply_stimulus(1'b0, 1'b0, 2'b00);

        do_reset();
        for (int k = 1; k <= 30; k++) begin
            run_cycle();
            check_val("tick_period", 8'(cnt_en), 8'(k == 10 || k == 20 || k == 30));
            check_val("an_scan", 8'(an), 8'(an_tab[(k / 2) % 4]));
        end

        do_reset();
        for (int k = 1; k <= 46; k++) begin
            run_cycle();
            check_val("pause_cnt_en", 8'(cnt_en), 8'(k == 10 || k == 36 || k == 46));
            check_val("pause_run", 8'(run), 8'(!(k >= 19 && k <= 34)));
            if (k == 13 || k == 29) pause = 1'b1;
            if (k == 19 || k == 35) pause = 1'b0;
        end

        do_reset();
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].pause, vecs[i].select, vecs[i].adj);
            repeat (vecs[i].hold) run_cycle();
            check_val("table_run", 8'(run), 8'(vecs[i].exp_run));
        end

        do_reset();
        apply_stimulus(1'b0, 1'b1, 2'b01);
        for (int k = 1; k <= 60; k++) begin
            run_cycle();
            if (k <= 30) begin
                check_val("adj_no_tick", 8'(cnt_en), 8'(0));
                check_val("adj_sec_step", 8'(adj_sec_en), 8'(k >= 11 && (k - 11) % 8 == 0));
                check_val("adj_blank", 8'(digit_blank), 8'(k >= 3 && ((k / 3) % 2) == 1 && ((k / 2) % 4) < 2));
            end else if (k >= 35 && k <= 44) begin
                check_val("fast_min_step", 8'(adj_min_en), 8'((k % 2) == 1));
                check_val("fast_no_sec", 8'(adj_sec_en), 8'(0));
            end else if (k >= 48) begin
                check_val("exit_cnt_en", 8'(cnt_en), 8'(k == 57));
                check_val("exit_no_adj", 8'(adj_min_en | adj_sec_en), 8'(0));
                check_val("exit_run", 8'(run), 8'(1));
            end
            if (k == 30) apply_stimulus(1'b0, 1'b0, 2'b11);
            if (k == 44) apply_stimulus(1'b0, 1'b0, 2'b00);
        end

        do_reset();
        apply_stimulus(1'b0, 1'b1, 2'b01);
        repeat (11) run_cycle();
        check_val("pre_reset_an", 8'(an), 8'(4'b1101));
        check_val("pre_reset_sec", 8'(adj_sec_en), 8'(1));
        check_val("pre_reset_blank", 8'(digit_blank), 8'(1));
        resett = 1'b0;
        #1;
        check_reset_values("async_reset");
        apply_stimulus(1'b0, 1'b0, 2'b00);
        repeat (2) @(negedge clk);
        resett = 1'b1;
        repeat (10) run_cycle();
        check_val("post_reset_tick", 8'(cnt_en), 8'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
